// File: rtl/tt_vpu_pkg.sv
// ---------------------------------------------------------------------------
// tt_vpu_pkg
// Shared types for the VPU issue-side speculative queue.
//   iq_entry_t : one queue entry (opaque payload, scoreboard id, senior bit)
//                sized for the default queue configuration.
//   iq_ptr_t   : circular-buffer pointer with wrap-phase bit.
//   disp_cmd_e : last dispatch command seen, used to filter repeated kills.
// ---------------------------------------------------------------------------
package tt_vpu_pkg;

  localparam int unsigned IQ_DEPTH     = 8;
  localparam int unsigned IQ_PAYLOAD_W = 137;
  localparam int unsigned IQ_SBID_W    = 5;
  localparam int unsigned IQ_AW        = $clog2(IQ_DEPTH);

  typedef struct packed {
    logic [IQ_PAYLOAD_W-1:0] payload;
    logic [IQ_SBID_W-1:0]    sb_id;
    logic                    senior;
  } iq_entry_t;

  typedef struct packed {
    logic             phase;
    logic [IQ_AW-1:0] idx;
  } iq_ptr_t;

  typedef enum logic [1:0] {
    DCMD_NONE   = 2'd0,
    DCMD_SENIOR = 2'd1,
    DCMD_KILL   = 2'd2
  } disp_cmd_e;

endpackage

// File: rtl/tt_phase_ptr.sv
// ---------------------------------------------------------------------------
// tt_phase_ptr
// Circular-buffer pointer with a wrap-phase bit in the MSB.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (pointer -> 0)
//   inc_i           : advance pointer by one
//   load_i          : load load_val_i (takes priority over inc_i)
//   load_val_i      : pointer+phase value to load
//   ptr_o           : current {phase, index}
// ---------------------------------------------------------------------------
module tt_phase_ptr #(
  parameter int unsigned AW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [AW:0] load_val_i,
  output logic [AW:0] ptr_o
);

  logic [AW:0] ptr_q;
  logic [AW:0] ptr_d;

  // Next pointer: the depth is a power of two, so the carry out of the index
  // field on wrap from DEPTH-1 toggles the phase bit for free.
  always_comb begin
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/tt_spec_issue_queue.sv
// ---------------------------------------------------------------------------
// tt_spec_issue_queue
// Speculative in-order issue queue. Entries are pushed speculatively; the
// dispatcher either promotes the oldest speculative entry to senior
// (disp_senior) or discards all speculative entries (disp_kill). Only senior
// entries can leave through the pop port.
//   Region [rd_ptr, disp_ptr) : senior entries, poppable in order
//   Region [disp_ptr, wr_ptr) : speculative entries, discarded on kill
// Ports:
//   clk, reset                      : clock, async active-high reset
//   push_valid/ready/payload/sb_id  : enqueue handshake and entry contents
//   disp_senior/kill/sb_id          : dispatch commands
//   pop_valid/ready/payload/sb_id   : head-entry handshake
//   count                           : occupied entries
//   credit_ret                      : one-cycle pulse per popped entry
//   proto_err                       : sticky dispatch protocol error
// Build option:
//   TT_SPEC_ISSUE_QUEUE_SBID_CHECK_EN : compare disp_sb_id against the entry
//   being promoted; a mismatch raises proto_err (promotion still happens).
// ---------------------------------------------------------------------------
module tt_spec_issue_queue
  import tt_vpu_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAYLOAD_W = 137,
  parameter int unsigned SBID_W    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [PAYLOAD_W-1:0]       push_payload,
  input  logic [SBID_W-1:0]          push_sb_id,
  input  logic                       disp_senior,
  input  logic                       disp_kill,
  input  logic [SBID_W-1:0]          disp_sb_id,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [PAYLOAD_W-1:0]       pop_payload,
  output logic [SBID_W-1:0]          pop_sb_id,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       credit_ret,
  output logic                       proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0] pl_mem [DEPTH];
  logic [SBID_W-1:0]    sb_mem [DEPTH];
  logic [DEPTH-1:0]     senior_q, senior_d;
  disp_cmd_e            last_cmd_q, last_cmd_d;
  logic                 proto_err_q, proto_err_d;
  logic                 credit_q;

  logic [AW:0]   wr_ptr, rd_ptr, disp_ptr;
  logic [AW-1:0] wr_idx, rd_idx, disp_idx;
  logic [AW:0]   occ;
  logic          full, empty;
  logic          push_fire, pop_fire;
  logic          push_at_disp, sen_ok, kill_ok, sb_mismatch;

  assign wr_idx   = wr_ptr[AW-1:0];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign disp_idx = disp_ptr[AW-1:0];

  // Phase-extended subtraction gives 0..DEPTH without ambiguity.
  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == (AW+1)'(DEPTH));
  assign empty = (occ == '0);

  assign push_ready = !full && !disp_kill;
  assign push_fire  = push_valid && push_ready;
  assign pop_valid  = !empty && senior_q[rd_idx];
  assign pop_fire   = pop_valid && pop_ready;

  // No speculative entry exists when disp_ptr has caught up with wr_ptr;
  // then only a same-cycle push can be promoted.
  assign push_at_disp = (disp_ptr == wr_ptr);
  assign sen_ok       = disp_senior && (!push_at_disp || push_fire);
  // A kill alongside a senior is ignored; a kill right after a kill is a no-op.
  assign kill_ok      = disp_kill && !disp_senior && (last_cmd_q != DCMD_KILL);

`ifdef TT_SPEC_ISSUE_QUEUE_SBID_CHECK_EN
  logic [SBID_W-1:0] exp_sb_id;
  assign exp_sb_id   = push_at_disp ? push_sb_id : sb_mem[disp_idx];
  assign sb_mismatch = sen_ok && (disp_sb_id != exp_sb_id);
`else
  logic unused_disp_sb_id;
  assign unused_disp_sb_id = ^disp_sb_id;
  assign sb_mismatch       = 1'b0;
`endif

  tt_phase_ptr #(.AW(AW)) u_wr_ptr (
    .clk(clk), .reset(reset), .inc_i(push_fire), .load_i(kill_ok),
    .load_val_i(disp_ptr), .ptr_o(wr_ptr)
  );

  tt_phase_ptr #(.AW(AW)) u_rd_ptr (
    .clk(clk), .reset(reset), .inc_i(pop_fire), .load_i(1'b0),
    .load_val_i('0), .ptr_o(rd_ptr)
  );

  tt_phase_ptr #(.AW(AW)) u_disp_ptr (
    .clk(clk), .reset(reset), .inc_i(sen_ok), .load_i(1'b0),
    .load_val_i('0), .ptr_o(disp_ptr)
  );

  // Senior bits: a promotion of the slot being written this cycle wins.
  always_comb begin
    senior_d = senior_q;
    if (pop_fire) begin
      senior_d[rd_idx] = 1'b0;
    end
    if (push_fire) begin
      senior_d[wr_idx] = 1'b0;
    end
    if (sen_ok) begin
      senior_d[disp_idx] = 1'b1;
    end
  end

  // Last dispatch command and sticky protocol error
  always_comb begin
    if (disp_senior) begin
      last_cmd_d = DCMD_SENIOR;
    end else if (disp_kill) begin
      last_cmd_d = DCMD_KILL;
    end else begin
      last_cmd_d = last_cmd_q;
    end
    proto_err_d = proto_err_q
                | (disp_senior && !sen_ok)
                | (disp_senior && disp_kill)
                | sb_mismatch;
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      senior_q    <= '0;
      last_cmd_q  <= DCMD_NONE;
      proto_err_q <= 1'b0;
      credit_q    <= 1'b0;
    end else begin
      senior_q    <= senior_d;
      last_cmd_q  <= last_cmd_d;
      proto_err_q <= proto_err_d;
      credit_q    <= pop_fire;
    end
  end

  // Entry storage; contents are only meaningful while pop_valid is high
  always_ff @(posedge clk) begin
    if (push_fire) begin
      pl_mem[wr_idx] <= push_payload;
      sb_mem[wr_idx] <= push_sb_id;
    end
  end

  assign pop_payload = pl_mem[rd_idx];
  assign pop_sb_id   = sb_mem[rd_idx];
  assign count       = occ;
  assign credit_ret  = credit_q;
  assign proto_err   = proto_err_q;

endmodule

// File: doc/tt_spec_issue_queue.md
TT_SPEC_ISSUE_QUEUE -- requirements
Module: tt_spec_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8: entry count; power of two, >=2.
REQ-002 Parameter PAYLOAD_W, default 137: opaque payload width (inst+scalar opnd+vcsr+lmulb2).
REQ-003 Parameter SBID_W, default 5: scoreboard-id width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 push_valid  in  1  issue-side entry offered.
REQ-007 push_ready  out  1  entry accepted when push_valid && push_ready.
REQ-008 push_payload, push_sb_id  in  PAYLOAD_W, SBID_W  entry contents.
REQ-009 disp_senior, disp_kill, disp_sb_id  in  1, 1, SBID_W  dispatch commands.
REQ-010 pop_valid, pop_ready  out, in  1, 1  head handshake.
REQ-011 pop_payload, pop_sb_id  out  PAYLOAD_W, SBID_W  head entry.
REQ-012 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-013 credit_ret  out  1  one-cycle pulse per popped entry.
REQ-014 proto_err  out  1  sticky protocol-error flag.

Function
REQ-015 Storage: DEPTH-entry circular buffer; wr_ptr, rd_ptr, disp_ptr, each with wrap-phase bit.
REQ-016 push_ready = !full && !disp_kill; full when count==DEPTH.
REQ-017 Accepted push writes entry at wr_ptr, clears its senior bit, advances wr_ptr; visible to pop no earlier than next cycle.
REQ-018 disp_senior sets senior bit at disp_ptr, advances disp_ptr; same-cycle push into disp_ptr==wr_ptr sets incoming entry senior directly.
REQ-019 disp_kill, when previous dispatch command was not kill, sets wr_ptr/phase to disp_ptr/phase, discarding all non-senior entries; repeated kill without intervening senior is ignored.
REQ-020 disp_senior with no non-senior entry present (and no same-cycle push) sets proto_err; pointers unchanged.
REQ-021 disp_senior and disp_kill in same cycle: proto_err set, senior processed, kill ignored.
REQ-022 pop_valid = !empty && senior bit of entry at rd_ptr; pop advances rd_ptr, clears senior bit, pulses credit_ret next cycle.
REQ-023 Pop and push same cycle when full: pop completes, push refused (push_ready reflects registered count).
REQ-024 count = wr_ptr-rd_ptr with phase, updated every cycle; never exceeds DEPTH.
REQ-025 Pointer wrap at DEPTH-1 toggles phase bit; count correct across wrap.

Reset
REQ-026 Asserting reset immediately clears all pointers, phases, senior bits, last-kill flag, proto_err; count=0, pop_valid=0, credit_ret=0, push_ready=1 after release.
REQ-027 Payload storage is not reset; pop_payload undefined while pop_valid=0.
REQ-028 Reset mid-operation discards all entries, no credit_ret pulses generated.

Configuration
REQ-029 Macro TT_SPEC_ISSUE_QUEUE_SBID_CHECK_EN: when defined, disp_senior compares disp_sb_id with sb_id at disp_ptr (or push_sb_id if same-cycle push); mismatch sets proto_err, senior still applied.
REQ-030 Without the macro, disp_sb_id is ignored and no comparison logic exists.

Structure
REQ-031 Shared package tt_vpu_pkg holds entry struct (payload, sb_id, senior) and pointer-with-phase typedef, parametrised by localparams.
REQ-032 One sub-module tt_phase_ptr: pointer+phase register with increment, load, wrap; instantiated three times.

Verification
REQ-033 DEPTH=4: push 4 entries no dispatch -> push_ready=0, count=4, pop_valid=0.
REQ-034 Push sb 1,2,3; senior x1; kill -> count=1, pop sb 1, credit_ret one pulse, count=0.
REQ-035 Push with same-cycle disp_senior into empty queue -> pop_valid=1 next cycle, sb matches.
REQ-036 Fill/pop 10 entries over wrap with interleaved senior -> in-order sb_ids, count never >4, proto_err=0.
REQ-037 Kill twice consecutively, then senior with empty speculative region -> second kill ignored, proto_err=1.
REQ-038 Macro defined: senior with disp_sb_id=7 vs entry sb 3 -> proto_err=1; reset asserted mid-stream -> count=0 immediately, proto_err=0.
